// File: rtl/l1_vy_hakem_pkg.sv
// Shared constants and state encoding for the L1 bus arbiter.
// Default widths match the L1 address and block widths used on the vy controller port.
package l1_vy_hakem_pkg;

  localparam int ADRES_BIT   = 32;
  localparam int L1_BLOK_BIT = 128;

  typedef enum logic [1:0] {
    HAKEM_BOSTA = 2'd0,
    HAKEM_ISTEK = 2'd1,
    HAKEM_YANIT = 2'd2
  } hakem_durum_t;

endpackage

// File: rtl/l1_vy_hakem.sv
// Round-robin arbiter sharing one vy controller L1 port between the L1 instruction (port 0)
// and L1 data (port 1) controllers, with one transaction outstanding at a time.
module l1_vy_hakem
  import l1_vy_hakem_pkg::*;
#(
  parameter int ADRES_W = ADRES_BIT,
  parameter int BLOK_W  = L1_BLOK_BIT
) (
  input  logic               io_l1bd_clk_w,
  input  logic               resetn,
  input  logic [ADRES_W-1:0] p0_istek_adres_i,
  input  logic               p0_istek_gecerli_i,
  input  logic               p0_istek_yaz_i,
  input  logic [BLOK_W-1:0]  p0_istek_veri_i,
  output logic               p0_istek_hazir_o,
  output logic [BLOK_W-1:0]  p0_veri_o,
  output logic               p0_veri_gecerli_o,
  input  logic               p0_veri_hazir_i,
  input  logic [ADRES_W-1:0] p1_istek_adres_i,
  input  logic               p1_istek_gecerli_i,
  input  logic               p1_istek_yaz_i,
  input  logic [BLOK_W-1:0]  p1_istek_veri_i,
  output logic               p1_istek_hazir_o,
  output logic [BLOK_W-1:0]  p1_veri_o,
  output logic               p1_veri_gecerli_o,
  input  logic               p1_veri_hazir_i,
  output logic [ADRES_W-1:0] vy_istek_adres_o,
  output logic               vy_istek_gecerli_o,
  output logic               vy_istek_yaz_o,
  output logic [BLOK_W-1:0]  vy_istek_veri_o,
  input  logic               vy_istek_hazir_i,
  input  logic [BLOK_W-1:0]  vy_veri_i,
  input  logic               vy_veri_gecerli_i,
  output logic               vy_veri_hazir_o
);

  hakem_durum_t       durum_q, durum_d;
  logic               son_kazanan_q, son_kazanan_d;
  logic               sahip_q, sahip_d;
  logic [ADRES_W-1:0] adres_q, adres_d;
  logic               yaz_q, yaz_d;
  logic [BLOK_W-1:0]  veri_q, veri_d;

  logic [1:0]         istek_gecerli;
  logic [1:0]         veri_hazir;
  logic [1:0]         kabul;
  logic               kazanan;
  logic               yanit;
  logic [1:0]         veri_gecerli_w;
  logic [BLOK_W-1:0]  veri_w [2];

  assign istek_gecerli = {p1_istek_gecerli_i, p0_istek_gecerli_i};
  assign veri_hazir    = {p1_veri_hazir_i, p0_veri_hazir_i};
  assign yanit         = (durum_q == HAKEM_YANIT);

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    kazanan = istek_gecerli[1];
    if (istek_gecerli == 2'b11) kazanan = ~son_kazanan_q;
  end

  always_comb begin
    durum_d       = durum_q;
    son_kazanan_d = son_kazanan_q;
    sahip_d       = sahip_q;
    adres_d       = adres_q;
    yaz_d         = yaz_q;
    veri_d        = veri_q;
    kabul         = 2'b00;
    unique case (durum_q)
      HAKEM_BOSTA: begin
        // No grant while resetn is low: the acceptance would be discarded by the reset edge.
        if ((|istek_gecerli) && resetn) begin
          kabul         = kazanan ? 2'b10 : 2'b01;
          sahip_d       = kazanan;
          son_kazanan_d = kazanan;
          adres_d       = kazanan ? p1_istek_adres_i : p0_istek_adres_i;
          yaz_d         = kazanan ? p1_istek_yaz_i   : p0_istek_yaz_i;
          veri_d        = kazanan ? p1_istek_veri_i  : p0_istek_veri_i;
          durum_d       = HAKEM_ISTEK;
        end
      end
      HAKEM_ISTEK: begin
        if (vy_istek_hazir_i) durum_d = yaz_q ? HAKEM_BOSTA : HAKEM_YANIT;
      end
      HAKEM_YANIT: begin
        if (vy_veri_gecerli_i && veri_hazir[sahip_q]) durum_d = HAKEM_BOSTA;
      end
      default: durum_d = HAKEM_BOSTA;
    endcase
  end

  always_ff @(posedge io_l1bd_clk_w) begin
    if (!resetn) begin
      durum_q       <= HAKEM_BOSTA;
      son_kazanan_q <= 1'b1;
      sahip_q       <= 1'b0;
      adres_q       <= '0;
      yaz_q         <= 1'b0;
      veri_q        <= '0;
    end else begin
      durum_q       <= durum_d;
      son_kazanan_q <= son_kazanan_d;
      sahip_q       <= sahip_d;
      adres_q       <= adres_d;
      yaz_q         <= yaz_d;
      veri_q        <= veri_d;
    end
  end

  // Response steering: only the owner sees the read block, the other port sees zeros.
  for (genvar gi = 0; gi < 2; gi++) begin : g_yanit
    assign veri_gecerli_w[gi] = yanit && (sahip_q == 1'(gi)) && vy_veri_gecerli_i;
    assign veri_w[gi]         = (yanit && (sahip_q == 1'(gi))) ? vy_veri_i : '0;
  end

  assign p0_istek_hazir_o   = kabul[0];
  assign p1_istek_hazir_o   = kabul[1];
  assign p0_veri_o          = veri_w[0];
  assign p1_veri_o          = veri_w[1];
  assign p0_veri_gecerli_o  = veri_gecerli_w[0];
  assign p1_veri_gecerli_o  = veri_gecerli_w[1];

  assign vy_istek_gecerli_o = (durum_q == HAKEM_ISTEK);
  assign vy_istek_adres_o   = adres_q;
  assign vy_istek_yaz_o     = yaz_q;
  assign vy_istek_veri_o    = veri_q;
  assign vy_veri_hazir_o    = yanit && veri_hazir[sahip_q];

endmodule

// File: tb/tb_l1_vy_hakem.sv
// Directed self-checking bench for the two-port L1 arbiter: grants, fairness, writes,
// response backpressure, reset during a response and stray downstream data.
module tb_l1_vy_hakem;

  localparam int AW = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] p0_adres, p1_adres;
  logic          p0_gecerli, p1_gecerli, p0_yaz, p1_yaz;
  logic [BW-1:0] p0_wveri, p1_wveri;
  logic          p0_hazir, p1_hazir;
  logic [BW-1:0] p0_veri, p1_veri;
  logic          p0_vgecerli, p1_vgecerli;
  logic          p0_vhazir, p1_vhazir;
  logic [AW-1:0] vy_adres;
  logic          vy_gecerli, vy_yaz;
  logic [BW-1:0] vy_wveri;
  logic          vy_ihazir;
  logic [BW-1:0] vy_veri;
  logic          vy_vgecerli;
  logic          vy_vhazir;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l1_vy_hakem dut (
    .io_l1bd_clk_w      (clk),
    .resetn             (resetn),
    .p0_istek_adres_i   (p0_adres),
    .p0_istek_gecerli_i (p0_gecerli),
    .p0_istek_yaz_i     (p0_yaz),
    .p0_istek_veri_i    (p0_wveri),
    .p0_istek_hazir_o   (p0_hazir),
    .p0_veri_o          (p0_veri),
    .p0_veri_gecerli_o  (p0_vgecerli),
    .p0_veri_hazir_i    (p0_vhazir),
    .p1_istek_adres_i   (p1_adres),
    .p1_istek_gecerli_i (p1_gecerli),
    .p1_istek_yaz_i     (p1_yaz),
    .p1_istek_veri_i    (p1_wveri),
    .p1_istek_hazir_o   (p1_hazir),
    .p1_veri_o          (p1_veri),
    .p1_veri_gecerli_o  (p1_vgecerli),
    .p1_veri_hazir_i    (p1_vhazir),
    .vy_istek_adres_o   (vy_adres),
    .vy_istek_gecerli_o (vy_gecerli),
    .vy_istek_yaz_o     (vy_yaz),
    .vy_istek_veri_o    (vy_wveri),
    .vy_istek_hazir_i   (vy_ihazir),
    .vy_veri_i          (vy_veri),
    .vy_veri_gecerli_i  (vy_vgecerli),
    .vy_veri_hazir_o    (vy_vhazir)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_adres = '0; p1_adres = '0; p0_gecerli = 0; p1_gecerli = 0;
    p0_yaz = 0; p1_yaz = 0; p0_wveri = '0; p1_wveri = '0;
    p0_vhazir = 0; p1_vhazir = 0; vy_ihazir = 0; vy_veri = '0; vy_vgecerli = 0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    step(); step();
    resetn = 1;
    #1;
    n_cmp++; if (vy_gecerli !== 1'b0) begin n_err++; $display("FAIL reset_vy_gecerli: got %0h want 0", vy_gecerli); end
    n_cmp++; if (vy_adres !== '0) begin n_err++; $display("FAIL reset_vy_adres: got %0h want 0", vy_adres); end
    n_cmp++; if ({p0_hazir, p1_hazir, p0_vgecerli, p1_vgecerli, vy_vhazir, vy_yaz} !== 6'b0) begin n_err++; $display("FAIL reset_flags: got %b want 000000", {p0_hazir, p1_hazir, p0_vgecerli, p1_vgecerli, vy_vhazir, vy_yaz}); end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_read();
    p0_gecerli = 1; p0_yaz = 0; p0_adres = 32'h100; p0_vhazir = 1;
    #1;
    n_cmp++; if (p0_hazir !== 1'b1 || p1_hazir !== 1'b0) begin n_err++; $display("FAIL rd_grant: got p0=%0h p1=%0h want p0=1 p1=0", p0_hazir, p1_hazir); end
    step();
    p0_gecerli = 0;
    #1;
    n_cmp++; if (vy_gecerli !== 1'b1 || vy_adres !== 32'h100 || vy_yaz !== 1'b0) begin n_err++; $display("FAIL rd_istek: got v=%0h a=%0h y=%0h want v=1 a=100 y=0", vy_gecerli, vy_adres, vy_yaz); end
    n_cmp++; if (p0_hazir !== 1'b0) begin n_err++; $display("FAIL rd_hazir_pulse: got %0h want 0", p0_hazir); end
    vy_ihazir = 1;
    step();
    vy_ihazir = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (p0_vgecerli !== 1'b0 || vy_vhazir !== 1'b1 || vy_gecerli !== 1'b0) begin n_err++; $display("FAIL rd_wait%0d: got vg=%0h vh=%0h ig=%0h want 0 1 0", i, p0_vgecerli, vy_vhazir, vy_gecerli); end
      step();
    end
    vy_vgecerli = 1; vy_veri = 128'hCAFE;
    #1;
    n_cmp++; if (p0_veri !== 128'hCAFE || p0_vgecerli !== 1'b1 || p1_vgecerli !== 1'b0) begin n_err++; $display("FAIL rd_data: got %0h g0=%0h g1=%0h want cafe 1 0", p0_veri, p0_vgecerli, p1_vgecerli); end
    step();
    vy_vgecerli = 0; vy_veri = '0;
    #1;
    n_cmp++; if (vy_vhazir !== 1'b0 || vy_gecerli !== 1'b0 || p0_vgecerli !== 1'b0) begin n_err++; $display("FAIL rd_done: got vh=%0h ig=%0h vg=%0h want 0 0 0", vy_vhazir, vy_gecerli, p0_vgecerli); end
    $display("single_read: p0 read 0x100 -> 0xCAFE");
  endtask

  task automatic test_tie_fair();
    idle();
    resetn = 0;
    step();
    resetn = 1;
    p0_gecerli = 1; p0_adres = 32'h10; p1_gecerli = 1; p1_adres = 32'h20;
    p0_vhazir = 1; p1_vhazir = 1;
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = 1'(i % 2);
      #1;
      n_cmp++; if (p0_hazir !== ~w || p1_hazir !== w) begin n_err++; $display("FAIL tie_grant%0d: got p0=%0h p1=%0h want winner %0d", i, p0_hazir, p1_hazir, w); end
      step();
      n_cmp++; if (vy_gecerli !== 1'b1 || vy_adres !== (w ? 32'h20 : 32'h10)) begin n_err++; $display("FAIL tie_adres%0d: got v=%0h a=%0h want v=1 a=%0h", i, vy_gecerli, vy_adres, (w ? 32'h20 : 32'h10)); end
      vy_ihazir = 1;
      step();
      vy_ihazir = 0; vy_vgecerli = 1; vy_veri = 128'hD0 + 128'(i);
      #1;
      n_cmp++; if (p0_vgecerli !== ~w || p1_vgecerli !== w) begin n_err++; $display("FAIL tie_owner%0d: got g0=%0h g1=%0h want owner %0d", i, p0_vgecerli, p1_vgecerli, w); end
      step();
      vy_vgecerli = 0; vy_veri = '0;
      $display("tie: txn %0d granted to port %0d", i, w);
    end
    p0_gecerli = 0; p1_gecerli = 0;
  endtask

  task automatic test_write();
    p1_gecerli = 1; p1_yaz = 1; p1_adres = 32'h200; p1_wveri = 128'h55;
    #1;
    n_cmp++; if (p1_hazir !== 1'b1 || p0_hazir !== 1'b0) begin n_err++; $display("FAIL wr_grant: got p0=%0h p1=%0h want 0 1", p0_hazir, p1_hazir); end
    step();
    p1_gecerli = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (vy_gecerli !== 1'b1 || vy_yaz !== 1'b1 || vy_adres !== 32'h200 || vy_wveri !== 128'h55) begin n_err++; $display("FAIL wr_stall%0d: got v=%0h y=%0h a=%0h d=%0h want 1 1 200 55", i, vy_gecerli, vy_yaz, vy_adres, vy_wveri); end
      step();
    end
    vy_ihazir = 1;
    step();
    vy_ihazir = 0; p1_yaz = 0; p1_adres = '0; p1_wveri = '0;
    #1;
    n_cmp++; if (vy_gecerli !== 1'b0 || p1_vgecerli !== 1'b0) begin n_err++; $display("FAIL wr_done: got ig=%0h g1=%0h want 0 0", vy_gecerli, p1_vgecerli); end
    $display("write: p1 write 0x200 <- 0x55 after 5 stall cycles");
  endtask

  task automatic test_stray();
    vy_vgecerli = 1; vy_veri = 128'hBAD; p0_vhazir = 1; p1_vhazir = 1;
    #1;
    n_cmp++; if (p0_vgecerli !== 1'b0 || p1_vgecerli !== 1'b0 || vy_vhazir !== 1'b0) begin n_err++; $display("FAIL stray: got g0=%0h g1=%0h vh=%0h want 0 0 0", p0_vgecerli, p1_vgecerli, vy_vhazir); end
    n_cmp++; if (p0_veri !== '0 || p1_veri !== '0) begin n_err++; $display("FAIL stray_data: got %0h %0h want 0 0", p0_veri, p1_veri); end
    p1_gecerli = 1; p1_yaz = 1; p1_adres = 32'h210;
    #1;
    n_cmp++; if (p1_hazir !== 1'b1) begin n_err++; $display("FAIL stray_bosta_grant: got %0h want 1", p1_hazir); end
    step();
    p1_gecerli = 0; vy_ihazir = 1;
    step();
    vy_ihazir = 0; vy_vgecerli = 0; vy_veri = '0; p1_yaz = 0;
    $display("stray: downstream data ignored while idle");
  endtask

  task automatic test_backpressure();
    p0_gecerli = 1; p0_yaz = 0; p0_adres = 32'h300; p0_vhazir = 0;
    step();
    p0_gecerli = 0; vy_ihazir = 1;
    step();
    vy_ihazir = 0; vy_vgecerli = 1; vy_veri = 128'hBEEF;
    p1_gecerli = 1; p1_yaz = 1; p1_adres = 32'h400;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (vy_vhazir !== 1'b0 || p0_vgecerli !== 1'b1 || p0_veri !== 128'hBEEF || p1_hazir !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d: got vh=%0h g0=%0h d=%0h h1=%0h want 0 1 beef 0", i, vy_vhazir, p0_vgecerli, p0_veri, p1_hazir); end
      step();
    end
    p0_vhazir = 1;
    #1;
    n_cmp++; if (vy_vhazir !== 1'b1) begin n_err++; $display("FAIL bp_release: got %0h want 1", vy_vhazir); end
    step();
    #1;
    n_cmp++; if (vy_vhazir !== 1'b0 || p0_vgecerli !== 1'b0 || p1_hazir !== 1'b1) begin n_err++; $display("FAIL bp_single: got vh=%0h g0=%0h h1=%0h want 0 0 1", vy_vhazir, p0_vgecerli, p1_hazir); end
    step();
    p1_gecerli = 0; vy_vgecerli = 0; vy_veri = '0;
    #1;
    n_cmp++; if (vy_adres !== 32'h400 || vy_yaz !== 1'b1) begin n_err++; $display("FAIL bp_next: got a=%0h y=%0h want 400 1", vy_adres, vy_yaz); end
    vy_ihazir = 1;
    step();
    vy_ihazir = 0; p1_yaz = 0;
    $display("backpressure: p0 read 0x300 held 4 cycles, then p1 write 0x400");
  endtask

  task automatic test_reset_mid();
    p0_gecerli = 1; p0_yaz = 0; p0_adres = 32'h500; p0_vhazir = 1;
    step();
    p0_gecerli = 0; vy_ihazir = 1;
    step();
    vy_ihazir = 0;
    p1_gecerli = 1; p1_yaz = 0; p1_adres = 32'h600; p1_vhazir = 1;
    vy_vgecerli = 1; vy_veri = 128'h77;
    resetn = 0;
    step();
    #1;
    n_cmp++; if ({vy_gecerli, vy_vhazir, p0_vgecerli, p1_vgecerli, p0_hazir, p1_hazir} !== 6'b0) begin n_err++; $display("FAIL rst_mid_outputs: got %b want 000000", {vy_gecerli, vy_vhazir, p0_vgecerli, p1_vgecerli, p0_hazir, p1_hazir}); end
    n_cmp++; if (vy_adres !== '0 || p0_veri !== '0) begin n_err++; $display("FAIL rst_mid_payload: got a=%0h d=%0h want 0 0", vy_adres, p0_veri); end
    resetn = 1;
    #1;
    n_cmp++; if (p1_hazir !== 1'b1 || p0_vgecerli !== 1'b0) begin n_err++; $display("FAIL rst_mid_p1_grant: got h1=%0h g0=%0h want 1 0", p1_hazir, p0_vgecerli); end
    vy_vgecerli = 0; vy_veri = '0;
    step();
    p1_gecerli = 0;
    #1;
    n_cmp++; if (vy_gecerli !== 1'b1 || vy_adres !== 32'h600) begin n_err++; $display("FAIL rst_mid_istek: got v=%0h a=%0h want 1 600", vy_gecerli, vy_adres); end
    vy_ihazir = 1;
    step();
    vy_ihazir = 0; vy_vgecerli = 1; vy_veri = 128'h66;
    #1;
    n_cmp++; if (p1_vgecerli !== 1'b1 || p1_veri !== 128'h66 || p0_vgecerli !== 1'b0) begin n_err++; $display("FAIL rst_mid_p1_data: got g1=%0h d=%0h g0=%0h want 1 66 0", p1_vgecerli, p1_veri, p0_vgecerli); end
    step();
    vy_vgecerli = 0; vy_veri = '0;
    $display("reset_mid: p0 response dropped, p1 read 0x600 served");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    resetn = 0;
    test_reset();
    test_single_read();
    test_tie_fair();
    test_write();
    test_stray();
    test_backpressure();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
